cdb_arbiter_buffer: RTL

Parametrised common-data-bus result buffer for the Tomasulo core. Each functional unit (FU) pushes completed results into its own FIFO. A round-robin arbiter selects one FIFO head per cycle and drives it onto a registered CDB broadcast port, which feeds the reservation stations and the register status table. FUs see back-pressure through per-FU ready signals, so no result is ever lost.

---
 rtl/cdb_pkg.sv | 28 ++
 rtl/cdb_result_fifo.sv | 82 ++++++++
 rtl/cdb_arbiter_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdb_pkg
// Description : Shared defaults and types for the CDB result buffer.
//               Provides default tag/data widths, the {tag, data} result
//               entry layout and a helper for index widths that must never
//               collapse to zero bits.
// Revision    : 1.0 - initial release
// ============================================================================
package cdb_pkg;

  localparam int c_DEF_TAG_W  = 4;
  localparam int c_DEF_DATA_W = 32;

  // Layout of one buffered FU result at the default widths. The top packs
  // its parameterised entries in the same {tag, data} order.
  typedef struct packed {
    logic [c_DEF_TAG_W-1:0]  tag;
    logic [c_DEF_DATA_W-1:0] data;
  } cdb_entry_t;

  // Width of an index into n items, at least one bit wide.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdb_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cdb_result_fifo
// Description : Per-FU result FIFO. The head entry is always visible on
//               head_data; pop consumes it. Occupancy is a separate counter
//               so full/empty never depend on pointer comparisons.
// Ports       : clk, reset (async, active-low), flush (sync clear),
//               push/push_data, pop/head_data, full, empty, count.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_PTR_W   = $clog2(DEPTH);
  localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
  localparam logic [c_PTR_W:0]   c_CNT_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W:0]   c_FULL    = (c_PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_PTR_W-1:0] wr_ptr_q;
  logic [c_PTR_W-1:0] rd_ptr_q;
  logic [c_PTR_W:0]   count_q;
  logic [c_PTR_W:0]   count_d;
  logic               w_push;
  logic               w_pop;

  // A full FIFO refuses pushes even when it is popped in the same cycle.
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign full      = (count_q == c_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + c_CNT_ONE;
    end else if (w_pop && !w_push) begin
      count_d = count_q - c_CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter_buffer.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter_buffer
// Description : Common-data-bus result buffer. One FIFO per functional unit,
//               a round-robin arbiter over non-empty FIFOs and a registered
//               CDB broadcast port (one result per cycle, no stall input).
// Ports       : clk, reset (async, active-low), flush (sync clear),
//               fu_valid/fu_tag/fu_data (packed per FU) -> fu_ready,
//               cdb_valid/cdb_tag/cdb_data/cdb_src broadcast,
//               fu_count per-FU occupancy (packed per FU).
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter_buffer
  import cdb_pkg::*;
#(
  parameter int NUM_FU = 2,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = c_DEF_TAG_W,
  parameter int DATA_W = c_DEF_DATA_W
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]              fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]             fu_data,
  output logic [NUM_FU-1:0]                    fu_ready,
  output logic                                 cdb_valid,
  output logic [TAG_W-1:0]                     cdb_tag,
  output logic [DATA_W-1:0]                    cdb_data,
  output logic [clog2_min1(NUM_FU)-1:0]        cdb_src,
  output logic [NUM_FU*($clog2(DEPTH)+1)-1:0]  fu_count
);

  localparam int c_SRC_W   = clog2_min1(NUM_FU);
  localparam int c_CNT_W   = $clog2(DEPTH) + 1;
  localparam int c_ENTRY_W = TAG_W + DATA_W;
  localparam logic [c_SRC_W-1:0] c_RR_RESET = c_SRC_W'(NUM_FU - 1);

  logic [c_ENTRY_W-1:0] w_head [NUM_FU];
  logic [NUM_FU-1:0]    w_full;
  logic [NUM_FU-1:0]    w_empty;
  logic [NUM_FU-1:0]    w_push;
  logic [NUM_FU-1:0]    w_pop;
  logic                 w_win_valid;
  logic [c_SRC_W-1:0]   w_win_idx;
  logic [c_SRC_W-1:0]   w_cand;
  logic [c_ENTRY_W-1:0] w_win_entry;

  logic                 cdb_valid_q;
  logic [TAG_W-1:0]     cdb_tag_q;
  logic [DATA_W-1:0]    cdb_data_q;
  logic [c_SRC_W-1:0]   cdb_src_q;
  logic [c_SRC_W-1:0]   rr_q;

  generate
    for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
      // Flush overrides both sides of every FIFO in the same cycle.
      assign w_push[i] = fu_valid[i] && !flush;
      assign w_pop[i]  = w_win_valid && (w_win_idx == c_SRC_W'(i)) && !flush;

      cdb_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (w_push[i]),
        .push_data ({fu_tag[i*TAG_W +: TAG_W], fu_data[i*DATA_W +: DATA_W]}),
        .pop       (w_pop[i]),
        .head_data (w_head[i]),
        .full      (w_full[i]),
        .empty     (w_empty[i]),
        .count     (fu_count[i*c_CNT_W +: c_CNT_W])
      );
    end
  endgenerate

  // Ready is from registered occupancy only, so a same-cycle pop does not
  // reopen a full FIFO.
  assign fu_ready = ~w_full;

  // Round-robin search: start one past the last winner and wrap.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      w_cand = c_SRC_W'((int'(rr_q) + k) % NUM_FU);
      if (!w_win_valid && !w_empty[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

  assign w_win_entry = w_head[w_win_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_q        <= c_RR_RESET;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      rr_q        <= c_RR_RESET;
    end else if (w_win_valid) begin
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= w_win_entry[c_ENTRY_W-1 -: TAG_W];
      cdb_data_q  <= w_win_entry[DATA_W-1:0];
      cdb_src_q   <= w_win_idx;
      rr_q        <= w_win_idx;
    end else begin
      // Idle: only valid drops; the last broadcast payload is held.
      cdb_valid_q <= 1'b0;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule
`default_nettype wire
